// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the execute-stage divide sequencer.
// Optional feature macro used by div_ctrl: DIV_EARLY_OUT_EN.
package div_ctrl_pkg;

  localparam int          DIV_WIDTH  = 32;
  localparam int          DIV_CNT_W  = 5;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Magnitude of a two's complement value when en is set, raw value otherwise.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result bundle between the execute stage and the divide sequencer.
// start/cancel are single-cycle requests; done+whilo_out mark one result write.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        stall;
  logic        stall_req;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        whilo_out;
  div_state_e  dbg_state;

  modport master (
    output start, signed_op, dividend, divisor, cancel, stall,
    input  stall_req, done, quotient, remainder, whilo_out, dbg_state
  );

  modport slave (
    input  start, signed_op, dividend, divisor, cancel, stall,
    output stall_req, done, quotient, remainder, whilo_out, dbg_state
  );

endinterface

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration: shift {rem,dvd} left, trial subtract,
// and shift the resulting quotient bit into the dividend LSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] dvd_next
);

  logic [WIDTH:0] rem_sh;
  logic           q_bit;
  logic           unused_rem_msb;

  // The partial remainder stays below dsr, so its top bit is always zero here.
  assign unused_rem_msb = rem[WIDTH];
  assign rem_sh         = {rem[WIDTH-1:0], dvd[WIDTH-1]};
  assign q_bit          = (rem_sh >= {1'b0, dsr});
  assign rem_next       = q_bit ? (rem_sh - {1'b0, dsr}) : rem_sh;
  assign dvd_next       = {dvd[WIDTH-2:0], q_bit};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: 32-step restoring divide with stall request,
// registered sign fix and HI/LO write strobe. Option macro: DIV_EARLY_OUT_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             done_q, done_d;
  logic             whilo_q, whilo_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic [WIDTH-1:0] a_mag, b_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .dsr      (dsr_q),
    .rem_next (step_rem),
    .dvd_next (step_dvd)
  );

  assign a_mag = mag(bus.dividend, bus.signed_op);
  assign b_mag = mag(bus.divisor, bus.signed_op);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    quot_d   = quot_q;
    remd_d   = remd_q;
    done_d   = done_q;
    whilo_d  = whilo_q;

    // cancel annuls whatever is in flight, including a same-cycle start.
    if (bus.cancel) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      whilo_d = 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state_d = DIV_DONE;
              quot_d  = DIV_ZERO_Q;
              remd_d  = bus.dividend;
              done_d  = 1'b1;
              whilo_d = 1'b1;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (a_mag < b_mag) begin
              state_d = DIV_DONE;
              quot_d  = '0;
              remd_d  = bus.dividend;
              done_d  = 1'b1;
              whilo_d = 1'b1;
            end
`endif
            else begin
              state_d  = DIV_RUN;
              cnt_d    = '0;
              rem_d    = '0;
              dvd_d    = a_mag;
              dsr_d    = b_mag;
              sign_q_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              sign_r_d = bus.signed_op & bus.dividend[WIDTH-1];
            end
          end
        end
        DIV_RUN: begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = DIV_DONE;
            quot_d  = neg_if(step_dvd, sign_q_q);
            remd_d  = neg_if(step_rem[WIDTH-1:0], sign_r_q);
            done_d  = 1'b1;
            whilo_d = 1'b1;
          end
        end
        DIV_DONE: begin
          if (!bus.stall) begin
            state_d = DIV_IDLE;
            done_d  = 1'b0;
            whilo_d = 1'b0;
          end
        end
        default: begin
          state_d = DIV_IDLE;
          done_d  = 1'b0;
          whilo_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      quot_q   <= '0;
      remd_q   <= '0;
      done_q   <= 1'b0;
      whilo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      quot_q   <= quot_d;
      remd_q   <= remd_d;
      done_q   <= done_d;
      whilo_q  <= whilo_d;
    end
  end

  // Combinational so the pipeline freezes in the very cycle start rises.
  assign bus.stall_req = ((state_q == DIV_IDLE) && bus.start && !bus.cancel) ||
                         (state_q == DIV_RUN);
  assign bus.done      = done_q;
  assign bus.whilo_out = whilo_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = remd_q;
  assign bus.dbg_state = state_q;

endmodule
